multi_alarm_ctrl: RTL and testbench
===================================

# multi_alarm_ctrl

Parametrised multi-channel alarm controller for the Basys3 clock design. It holds N_ALARMS independently settable and enabled alarm times, and compares them against the running time-of-day. Each channel follows its own ring/snooze/idle sequence, timed by a single-cycle 1 Hz tick. It sits beside the timekeeping counter and drives the alarm LED(s) and display readback.

## Interface
- N_ALARMS, 4, number of alarm channels (1..8); IDXW = max(1, clog2(N_ALARMS)) is a localparam
- RING_SECS, 10, seconds a channel rings before auto-timeout (1..63)
- SNOOZE_MIN, 5, snooze length in minutes (1..15)
- MAX_SNOOZE, 3, snoozes allowed per trigger; a further snooze acts as dismiss
- clk, in, 1, system clock
- reset, in, 1, asynchronous active-high reset
- tick_1hz, in, 1, one-clk-wide pulse once per second, synchronous to clk
- t_s, t_m, in, 6 each, current seconds/minutes (0..59)
- t_h, in, 5, current hours (0..23)
- set_time, in, 1, time-of-day being edited; suppresses triggering
- sel, in, IDXW, channel selected for edit/readback
- set_field, in, 3, one-hot edit field: 001 sec, 010 min, 100 hour, 000 none
- inc, in, 1, pulse: increment the selected field of channel sel
- en_toggle, in, 1, pulse: toggle alarm_en[sel]
- snooze, in, 1, pulse: snooze all ringing channels
- dismiss, in, 1, pulse: stop all ringing/snoozed channels
- rd_s, rd_m, out, 6 each, alarm sec/min of channel sel (combinational mux)
- rd_h, out, 5, alarm hour of channel sel
- alarm_en, out, N_ALARMS, channel enable flags
- ringing, out, N_ALARMS, channel in RING state
- snoozing, out, N_ALARMS, channel in SNOOZE state
- led_alarm, out, 1, OR of ringing

## Operation
- Reset values: all alarm times 00:00:00; alarm_en = 0; every channel IDLE; ringing, snoozing and led_alarm = 0; all counters 0.
- Edit: when inc=1 and set_field is nonzero, the field of channel sel increments. Seconds and minutes wrap 59->0; hours wrap 23->0. A set_field value that is not one-hot is ignored. Editing does not change channel state.
- Match for channel i: enabled, the time equals alarm time i, set_time=0, and set_field=000. Trigger is the rising edge of match, using a per-channel match_d register, so a match is counted once per occurrence.
- Per-channel FSM with states IDLE, RING and SNOOZE:
  - IDLE -> RING on trigger. Load ring_cnt=RING_SECS and clear snz_cnt.
  - In RING, each tick decrements ring_cnt. At 1->0 the channel goes to IDLE (timeout).
  - RING -> SNOOZE on snooze when snz_cnt < MAX_SNOOZE. Load snz_tmr=SNOOZE_MIN*60 and increment snz_cnt.
  - RING -> IDLE on snooze when snz_cnt == MAX_SNOOZE.
  - In SNOOZE, each tick decrements snz_tmr. At 1->0 the channel goes to RING and ring_cnt reloads to RING_SECS.
  - RING or SNOOZE -> IDLE on dismiss, or when the channel is disabled by en_toggle.
- Priority, highest first: reset, disable, dismiss, snooze, trigger/timeout. A trigger while the channel is in RING or SNOOZE is ignored.
- If trigger and tick occur in the same cycle, the trigger loads ring_cnt and the tick is not counted.
- Channels are independent. snooze and dismiss act on all channels at once.
- Counter widths: ring_cnt clog2(RING_SECS+1); snz_tmr clog2(SNOOZE_MIN*60+1); snz_cnt clog2(MAX_SNOOZE+1). No counter wraps.

## Timing
- ringing[i] rises 1 clk after the cycle in which match rises.
- In RING without intervention, ringing stays high until the clk after the RING_SECS-th tick counted.
- snooze, dismiss and en_toggle take effect on the next clk edge.
- SNOOZE lasts exactly SNOOZE_MIN*60 ticks.
- rd_* are combinational: valid in the same cycle sel changes.
- Reset asserted mid-ring clears everything immediately (asynchronous).

## Test plan
Use N_ALARMS=2, RING_SECS=3, SNOOZE_MIN=1, MAX_SNOOZE=2 unless noted.
- Reset then run time through 00:00:00 -> no ringing; alarm_en=00, so there is no midnight trigger.
- Set ch0 to 07:30:05 via 5 second-incs, 30 minute-incs and 7 hour-incs, then en_toggle. Time reaches 07:30:05 -> ringing=01 one clk later and led_alarm=1; ringing clears after the 3rd tick.
- Wrap: 60 second-incs on ch1 -> rd_s returns to 0. 24 hour-incs -> rd_h=0.
- Snooze on ch0 while ringing -> snoozing=01. After 60 ticks ringing=01 again. Second snooze -> SNOOZE. Third snooze while ringing -> IDLE with no snoozing.
- ch0 and ch1 both at 12:00:00 -> ringing=11. One dismiss -> ringing=00 and snoozing=00. A dismiss and a snooze in the same cycle -> IDLE.
- Hold set_time=1 across a matching time -> no trigger. Assert reset mid-ring -> all outputs 0 asynchronously and alarm times read back 00:00:00.

Source files
------------

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: N independent alarm channels. Each channel has a settable
// alarm time, an enable flag and a ring/snooze/idle sequence paced by a 1 Hz tick.
module multi_alarm_ctrl #(
   parameter int N_ALARMS   = 4,
   parameter int RING_SECS  = 10,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3,
   localparam int IDXW      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_1hz,
   input  logic [5:0]          t_s,
   input  logic [5:0]          t_m,
   input  logic [4:0]          t_h,
   input  logic                set_time,
   input  logic [IDXW-1:0]     sel,
   input  logic [2:0]          set_field,
   input  logic                inc,
   input  logic                en_toggle,
   input  logic                snooze,
   input  logic                dismiss,
   output logic [5:0]          rd_s,
   output logic [5:0]          rd_m,
   output logic [4:0]          rd_h,
   output logic [N_ALARMS-1:0] alarm_en,
   output logic [N_ALARMS-1:0] ringing,
   output logic [N_ALARMS-1:0] snoozing,
   output logic                led_alarm
);

   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int RCW       = $clog2(RING_SECS + 1);
   localparam int STW       = $clog2(SNZ_TICKS + 1);
   localparam int SCW_RAW   = $clog2(MAX_SNOOZE + 1);
   localparam int SCW       = (SCW_RAW > 0) ? SCW_RAW : 1;

   localparam logic [RCW-1:0] RING_LOAD = RCW'(RING_SECS);
   localparam logic [STW-1:0] SNZ_LOAD  = STW'(SNZ_TICKS);
   localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RING,
      ST_SNOOZE
   } ch_state_t;

   logic [5:0]          alm_s [N_ALARMS];
   logic [5:0]          alm_m [N_ALARMS];
   logic [4:0]          alm_h [N_ALARMS];
   logic [N_ALARMS-1:0] match;
   logic [N_ALARMS-1:0] match_d;
   logic [N_ALARMS-1:0] trigger;
   logic [N_ALARMS-1:0] disable_ch;

   ch_state_t           state_q    [N_ALARMS];
   ch_state_t           state_d    [N_ALARMS];
   logic [RCW-1:0]      ring_cnt_q [N_ALARMS];
   logic [RCW-1:0]      ring_cnt_d [N_ALARMS];
   logic [STW-1:0]      snz_tmr_q  [N_ALARMS];
   logic [STW-1:0]      snz_tmr_d  [N_ALARMS];
   logic [SCW-1:0]      snz_cnt_q  [N_ALARMS];
   logic [SCW-1:0]      snz_cnt_d  [N_ALARMS];

   // Alarm time editing: only a one-hot field selection increments, with modulo wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            alm_s[i] <= '0;
            alm_m[i] <= '0;
            alm_h[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            if (inc && (sel == IDXW'(i))) begin
               case (set_field)
                  3'b001: alm_s[i] <= (alm_s[i] == 6'd59) ? 6'd0 : alm_s[i] + 6'd1;
                  3'b010: alm_m[i] <= (alm_m[i] == 6'd59) ? 6'd0 : alm_m[i] + 6'd1;
                  3'b100: alm_h[i] <= (alm_h[i] == 5'd23) ? 5'd0 : alm_h[i] + 5'd1;
                  default: ;
               endcase
            end
         end
      end
   end

   // Enable flags flip on en_toggle; match_d remembers last cycle's match for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_en <= '0;
         match_d  <= '0;
      end else begin
         match_d <= match;
         for (int i = 0; i < N_ALARMS; i++) begin
            if (en_toggle && (sel == IDXW'(i))) begin
               alarm_en[i] <= ~alarm_en[i];
            end
         end
      end
   end

   // Match, trigger edge and "being disabled this cycle" per channel.
   always_comb begin
      match      = '0;
      disable_ch = '0;
      for (int i = 0; i < N_ALARMS; i++) begin
         match[i] = alarm_en[i] && (t_s == alm_s[i]) && (t_m == alm_m[i]) &&
                    (t_h == alm_h[i]) && !set_time && (set_field == 3'b000);
         disable_ch[i] = en_toggle && (sel == IDXW'(i)) && alarm_en[i];
      end
      trigger = match & ~match_d;
   end

   // Channel state and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            state_q[i]    <= ST_IDLE;
            ring_cnt_q[i] <= '0;
            snz_tmr_q[i]  <= '0;
            snz_cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_ALARMS; i++) begin
            state_q[i]    <= state_d[i];
            ring_cnt_q[i] <= ring_cnt_d[i];
            snz_tmr_q[i]  <= snz_tmr_d[i];
            snz_cnt_q[i]  <= snz_cnt_d[i];
         end
      end
   end

   // Next-state per channel; disable beats dismiss beats snooze beats trigger/timeout.
   always_comb begin
      for (int i = 0; i < N_ALARMS; i++) begin
         state_d[i]    = state_q[i];
         ring_cnt_d[i] = ring_cnt_q[i];
         snz_tmr_d[i]  = snz_tmr_q[i];
         snz_cnt_d[i]  = snz_cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (trigger[i] && !disable_ch[i] && !dismiss) begin
                  state_d[i]    = ST_RING;
                  ring_cnt_d[i] = RING_LOAD;
                  snz_cnt_d[i]  = '0;
               end
            end
            ST_RING: begin
               if (disable_ch[i] || dismiss) begin
                  state_d[i] = ST_IDLE;
               end else if (snooze) begin
                  if (snz_cnt_q[i] < SNZ_MAX) begin
                     state_d[i]   = ST_SNOOZE;
                     snz_tmr_d[i] = SNZ_LOAD;
                     snz_cnt_d[i] = snz_cnt_q[i] + SCW'(1);
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end else if (tick_1hz) begin
                  if (ring_cnt_q[i] <= RCW'(1)) begin
                     state_d[i]    = ST_IDLE;
                     ring_cnt_d[i] = '0;
                  end else begin
                     ring_cnt_d[i] = ring_cnt_q[i] - RCW'(1);
                  end
               end
            end
            ST_SNOOZE: begin
               if (disable_ch[i] || dismiss) begin
                  state_d[i] = ST_IDLE;
               end else if (tick_1hz) begin
                  if (snz_tmr_q[i] <= STW'(1)) begin
                     state_d[i]    = ST_RING;
                     snz_tmr_d[i]  = '0;
                     ring_cnt_d[i] = RING_LOAD;
                  end else begin
                     snz_tmr_d[i] = snz_tmr_q[i] - STW'(1);
                  end
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the channel states.
   always_comb begin
      ringing  = '0;
      snoozing = '0;
      for (int i = 0; i < N_ALARMS; i++) begin
         ringing[i]  = (state_q[i] == ST_RING);
         snoozing[i] = (state_q[i] == ST_SNOOZE);
      end
      led_alarm = |ringing;
   end

   // Readback mux of the selected channel's alarm time; out-of-range sel reads zero.
   always_comb begin
      rd_s = '0;
      rd_m = '0;
      rd_h = '0;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (sel == IDXW'(i)) begin
            rd_s = alm_s[i];
            rd_m = alm_m[i];
            rd_h = alm_h[i];
         end
      end
   end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed tests for multi_alarm_ctrl with two channels,
// 3 s ring time, 1 min snooze and two snoozes per trigger.
module tb_multi_alarm_ctrl;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         tick_1hz = 1'b0;
   logic [5:0]   t_s = '0;
   logic [5:0]   t_m = '0;
   logic [4:0]   t_h = '0;
   logic         set_time = 1'b0;
   logic [0:0]   sel = '0;
   logic [2:0]   set_field = '0;
   logic         inc = 1'b0;
   logic         en_toggle = 1'b0;
   logic         snooze = 1'b0;
   logic         dismiss = 1'b0;
   logic [5:0]   rd_s;
   logic [5:0]   rd_m;
   logic [4:0]   rd_h;
   logic [N-1:0] alarm_en;
   logic [N-1:0] ringing;
   logic [N-1:0] snoozing;
   logic         led_alarm;

   int checks = 0;
   int errors = 0;

   multi_alarm_ctrl #(
      .N_ALARMS(N),
      .RING_SECS(3),
      .SNOOZE_MIN(1),
      .MAX_SNOOZE(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tick_1hz(tick_1hz),
      .t_s(t_s),
      .t_m(t_m),
      .t_h(t_h),
      .set_time(set_time),
      .sel(sel),
      .set_field(set_field),
      .inc(inc),
      .en_toggle(en_toggle),
      .snooze(snooze),
      .dismiss(dismiss),
      .rd_s(rd_s),
      .rd_m(rd_m),
      .rd_h(rd_h),
      .alarm_en(alarm_en),
      .ringing(ringing),
      .snoozing(snoozing),
      .led_alarm(led_alarm)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tod(input int h, input int m, input int s);
      t_h = 5'(h);
      t_m = 6'(m);
      t_s = 6'(s);
      step();
   endtask

   task automatic do_inc(input int ch, input logic [2:0] f, input int n);
      for (int k = 0; k < n; k++) begin
         sel = 1'(ch);
         set_field = f;
         inc = 1'b1;
         step();
         inc = 1'b0;
         set_field = 3'b000;
      end
   endtask

   task automatic do_toggle(input int ch);
      sel = 1'(ch);
      en_toggle = 1'b1;
      step();
      en_toggle = 1'b0;
   endtask

   task automatic do_tick(input int n);
      for (int k = 0; k < n; k++) begin
         tick_1hz = 1'b1;
         step();
         tick_1hz = 1'b0;
         step();
      end
   endtask

   task automatic do_snooze();
      snooze = 1'b1;
      step();
      snooze = 1'b0;
   endtask

   task automatic do_dismiss();
      dismiss = 1'b1;
      step();
      dismiss = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      checks++;
      if (ringing !== 2'b00 || snoozing !== 2'b00 || led_alarm !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_status: ring=%b snz=%b led=%b expected 00 00 0", ringing, snoozing, led_alarm);
      end
      checks++;
      if (alarm_en !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_en: got %b expected 00", alarm_en);
      end
      checks++;
      if (rd_s !== 6'd0 || rd_m !== 6'd0 || rd_h !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_rd: got %0d:%0d:%0d expected 0:0:0", rd_h, rd_m, rd_s);
      end
      reset = 1'b0;
      step();
      set_tod(23, 59, 59);
      set_tod(0, 0, 0);
      step();
      checks++;
      if (ringing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL midnight_disabled: ringing=%b expected 00", ringing);
      end
   endtask

   task automatic test_set_and_ring();
      do_inc(0, 3'b001, 5);
      do_inc(0, 3'b010, 30);
      do_inc(0, 3'b100, 7);
      sel = 1'b0;
      #1;
      checks++;
      if (rd_h !== 5'd7 || rd_m !== 6'd30 || rd_s !== 6'd5) begin
         errors++;
         $display("[TB] FAIL ch0_time: got %0d:%0d:%0d expected 7:30:5", rd_h, rd_m, rd_s);
      end
      do_toggle(0);
      checks++;
      if (alarm_en !== 2'b01) begin
         errors++;
         $display("[TB] FAIL ch0_enable: got %b expected 01", alarm_en);
      end
      set_tod(7, 30, 4);
      checks++;
      if (ringing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL pre_match: ringing=%b expected 00", ringing);
      end
      set_tod(7, 30, 5);
      checks++;
      if (ringing !== 2'b01 || led_alarm !== 1'b1) begin
         errors++;
         $display("[TB] FAIL trigger: ringing=%b led=%b expected 01 1", ringing, led_alarm);
      end
      do_tick(2);
      checks++;
      if (ringing !== 2'b01) begin
         errors++;
         $display("[TB] FAIL ring_after_2: ringing=%b expected 01", ringing);
      end
      do_tick(1);
      checks++;
      if (ringing !== 2'b00 || led_alarm !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout: ringing=%b led=%b expected 00 0", ringing, led_alarm);
      end
      set_tod(7, 30, 6);
   endtask

   task automatic test_wrap();
      do_inc(1, 3'b001, 59);
      sel = 1'b1;
      #1;
      checks++;
      if (rd_s !== 6'd59) begin
         errors++;
         $display("[TB] FAIL sec_59: got %0d expected 59", rd_s);
      end
      do_inc(1, 3'b001, 1);
      checks++;
      if (rd_s !== 6'd0) begin
         errors++;
         $display("[TB] FAIL sec_wrap: got %0d expected 0", rd_s);
      end
      do_inc(1, 3'b100, 23);
      checks++;
      if (rd_h !== 5'd23) begin
         errors++;
         $display("[TB] FAIL hour_23: got %0d expected 23", rd_h);
      end
      do_inc(1, 3'b100, 1);
      checks++;
      if (rd_h !== 5'd0) begin
         errors++;
         $display("[TB] FAIL hour_wrap: got %0d expected 0", rd_h);
      end
      do_inc(1, 3'b011, 2);
      checks++;
      if (rd_s !== 6'd0 || rd_m !== 6'd0 || rd_h !== 5'd0) begin
         errors++;
         $display("[TB] FAIL not_onehot: got %0d:%0d:%0d expected 0:0:0", rd_h, rd_m, rd_s);
      end
      sel = 1'b0;
      #1;
      checks++;
      if (rd_h !== 5'd7 || rd_m !== 6'd30 || rd_s !== 6'd5) begin
         errors++;
         $display("[TB] FAIL rd_comb: got %0d:%0d:%0d expected 7:30:5", rd_h, rd_m, rd_s);
      end
   endtask

   task automatic test_snooze();
      set_tod(7, 30, 4);
      set_tod(7, 30, 5);
      checks++;
      if (ringing !== 2'b01) begin
         errors++;
         $display("[TB] FAIL snz_trigger: ringing=%b expected 01", ringing);
      end
      do_snooze();
      checks++;
      if (snoozing !== 2'b01 || ringing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL snooze1: snz=%b ring=%b expected 01 00", snoozing, ringing);
      end
      do_tick(59);
      checks++;
      if (snoozing !== 2'b01) begin
         errors++;
         $display("[TB] FAIL snooze_59: snz=%b expected 01", snoozing);
      end
      do_tick(1);
      checks++;
      if (ringing !== 2'b01 || snoozing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL re_ring1: ring=%b snz=%b expected 01 00", ringing, snoozing);
      end
      do_snooze();
      checks++;
      if (snoozing !== 2'b01) begin
         errors++;
         $display("[TB] FAIL snooze2: snz=%b expected 01", snoozing);
      end
      do_tick(60);
      checks++;
      if (ringing !== 2'b01) begin
         errors++;
         $display("[TB] FAIL re_ring2: ring=%b expected 01", ringing);
      end
      do_snooze();
      checks++;
      if (ringing !== 2'b00 || snoozing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL snooze_limit: ring=%b snz=%b expected 00 00", ringing, snoozing);
      end
      set_tod(7, 30, 6);
   endtask

   task automatic test_dismiss();
      do_inc(0, 3'b100, 5);
      do_inc(0, 3'b010, 30);
      do_inc(0, 3'b001, 55);
      do_inc(1, 3'b100, 12);
      do_toggle(1);
      checks++;
      if (alarm_en !== 2'b11) begin
         errors++;
         $display("[TB] FAIL both_en: got %b expected 11", alarm_en);
      end
      set_tod(11, 59, 59);
      set_tod(12, 0, 0);
      checks++;
      if (ringing !== 2'b11 || led_alarm !== 1'b1) begin
         errors++;
         $display("[TB] FAIL both_ring: ring=%b led=%b expected 11 1", ringing, led_alarm);
      end
      do_dismiss();
      checks++;
      if (ringing !== 2'b00 || snoozing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL dismiss: ring=%b snz=%b expected 00 00", ringing, snoozing);
      end
      set_tod(12, 0, 1);
      set_tod(12, 0, 0);
      snooze = 1'b1;
      dismiss = 1'b1;
      step();
      snooze = 1'b0;
      dismiss = 1'b0;
      checks++;
      if (ringing !== 2'b00 || snoozing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL dismiss_over_snooze: ring=%b snz=%b expected 00 00", ringing, snoozing);
      end
      set_tod(12, 0, 1);
      set_tod(12, 0, 0);
      do_toggle(0);
      checks++;
      if (ringing !== 2'b10 || alarm_en !== 2'b10) begin
         errors++;
         $display("[TB] FAIL disable_ch0: ring=%b en=%b expected 10 10", ringing, alarm_en);
      end
      do_dismiss();
      set_tod(12, 0, 1);
      do_toggle(0);
   endtask

   task automatic test_set_time();
      set_time = 1'b1;
      set_tod(12, 0, 0);
      step();
      checks++;
      if (ringing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL set_time_block: ring=%b expected 00", ringing);
      end
      set_tod(12, 0, 1);
      set_time = 1'b0;
      step();
      checks++;
      if (ringing !== 2'b00) begin
         errors++;
         $display("[TB] FAIL set_time_release: ring=%b expected 00", ringing);
      end
   endtask

   task automatic test_reset_mid_ring();
      set_tod(12, 0, 0);
      checks++;
      if (ringing !== 2'b11) begin
         errors++;
         $display("[TB] FAIL prereset_ring: ring=%b expected 11", ringing);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (ringing !== 2'b00 || snoozing !== 2'b00 || led_alarm !== 1'b0 || alarm_en !== 2'b00) begin
         errors++;
         $display("[TB] FAIL async_reset: ring=%b snz=%b led=%b en=%b expected all 0", ringing, snoozing, led_alarm, alarm_en);
      end
      sel = 1'b0;
      #1;
      checks++;
      if (rd_s !== 6'd0 || rd_m !== 6'd0 || rd_h !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_rd0: got %0d:%0d:%0d expected 0:0:0", rd_h, rd_m, rd_s);
      end
      sel = 1'b1;
      #1;
      checks++;
      if (rd_s !== 6'd0 || rd_m !== 6'd0 || rd_h !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_rd1: got %0d:%0d:%0d expected 0:0:0", rd_h, rd_m, rd_s);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_set_and_ring();
      test_wrap();
      test_snooze();
      test_dismiss();
      test_set_time();
      test_reset_mid_ring();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
